bcd_counter: RTL and testbench
==============================

Name: bcd_counter

Overview:
- Multi-decade synchronous BCD counter with up/down direction.
- Counts one step per clock-enable pulse, driven directly by a prescaler's CEO output (e.g. 1 Hz tick from the system clock).
- Emits a terminal-count enable (CEO) for cascading into further counters or a display/timer stage.
- Output feeds the seven-segment multiplexer downstream.

Parameters:
- DIGITS, 4, number of BCD decades (1..8); Q width = 4*DIGITS.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- CLR  input  1  synchronous, active-high reset; clears every digit to 0.
- CE  input  1  count enable, one-cycle pulse from the upstream prescaler.
- DIR  input  1  count direction: 0 = up, 1 = down.
- Q  output  4*DIGITS  packed BCD value; digit 0 = Q[3:0] (least significant).
- CEO  output  1  combinational terminal-count enable for cascading.
- LOAD  input  1  synchronous parallel load. Present only with BCD_LOAD_EN.
- DIN  input  4*DIGITS  parallel load value. Present only with BCD_LOAD_EN.

Behaviour:
- Reset:
  - CLR=1 at a rising edge sets Q to all zeros.
  - CLR has highest priority: it overrides LOAD, CE and DIR.
  - CEO is combinational, so during reset it follows CE and DIR applied to Q=0.
- Priority per edge: CLR > LOAD > CE count > hold.
- Hold: with CE=0 and no LOAD, Q keeps its value; DIR changes have no effect.
- Up count (DIR=0, CE=1):
  - Digit 0 increments.
  - A digit at 9 wraps to 0 and enables the next digit in the same edge (ripple enable, single-cycle, no pipelining).
  - 99..9 wraps to 00..0.
- Down count (DIR=1, CE=1):
  - Digit 0 decrements.
  - A digit at 0 wraps to 9 and enables the next digit.
  - 00..0 wraps to 99..9.
- Latency: Q reflects a CE pulse one cycle after the edge that samples CE=1.
- Per-digit carry/borrow:
  - en[0] = CE.
  - en[i+1] = en[i] & (DIR ? digit[i]==0 : digit[i]==9).
- CEO:
  - CEO = en[DIGITS], i.e. CE & all digits at terminal value for the current DIR.
  - CEO is asserted in the same cycle as the wrapping CE pulse.
  - Forced to 0 while LOAD=1 (BCD_LOAD_EN only).
  - No registered delay, so cascaded counters see it on the same edge.
- Invalid digits: Q never holds a nibble >9 in normal operation; the only entry point is LOAD, handled below.
- DIR changing in the same cycle as CE: the new DIR value is used for that edge; no glitch state.
- DIGITS=1: a single decade; CEO = CE & terminal value of digit 0.

Optional Feature:
- Macro BCD_LOAD_EN.
- Defined:
  - LOAD and DIN ports exist.
  - LOAD=1 (without CLR) loads DIN into Q on that edge, independent of CE.
  - Any DIN nibble >9 is stored as 0.
  - CEO is held at 0 during the load cycle.
- Undefined:
  - LOAD and DIN ports are absent.
  - Counter is reset/count/hold only.

Decomposition:
- Shared package/include holds:
  - BCD_DIGIT_W = 4
  - BCD_MAX = 4'd9
  - BCD_MIN = 4'd0
  - direction encodings DIR_UP = 1'b0, DIR_DOWN = 1'b1
- Sub-module bcd_digit: one decade with ports CLK, CLR, CE, DIR, optional LOAD/DIN nibble, Q[3:0], CEO.
- bcd_counter is a generate loop chaining bcd_digit CEO to the next digit's CE.

Test Plan:
- Reset and cascade: CLR=1 one cycle, then 10 CE pulses, DIR=0, DIGITS=4 -> Q=0x0010; CEO=0 throughout.
- Full-range up wrap: from Q=0x9999, one CE pulse with DIR=0 -> CEO=1 in that cycle, Q=0x0000 next cycle. Sparse CE (1 in 10 clocks) -> Q changes only on CE cycles.
- Down wrap and borrow chain: from Q=0x0000, DIR=1, one CE -> CEO=1, Q=0x9999. From Q=0x1000, one CE -> Q=0x0999.
- Priority: CLR=1, LOAD=1, CE=1 together at Q=0x4321 -> Q=0x0000. Next cycle CLR=0, LOAD=1, DIN=0x1234, CE=1 -> Q=0x1234, CEO=0 (BCD_LOAD_EN).
- Invalid load: DIN=0x9A3F with LOAD=1 -> Q=0x9030 (BCD_LOAD_EN).
- Direction flip: Q=0x0009, DIR toggled 0->1 in the same cycle as CE -> Q=0x0008. CE=0 with DIR toggling for 5 cycles -> Q unchanged.

Source files
------------

// File: rtl/bcd_counter_pkg.sv
// Shared constants and digit helpers for the BCD counter.
// Optional parallel load is enabled by defining BCD_LOAD_EN.
package bcd_counter_pkg;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam logic [3:0] BCD_MIN     = 4'd0;
  localparam logic       DIR_UP      = 1'b0;
  localparam logic       DIR_DOWN    = 1'b1;

  function automatic logic [3:0] bcd_step(
    input logic [3:0] d,
    input logic       dir
  );
    if (dir == DIR_DOWN)
      return (d == BCD_MIN) ? BCD_MAX : d - 4'd1;
    else
      return (d >= BCD_MAX) ? BCD_MIN : d + 4'd1;
  endfunction

  function automatic logic bcd_term(
    input logic [3:0] d,
    input logic       dir
  );
    return (dir == DIR_DOWN) ? (d == BCD_MIN)
                             : (d == BCD_MAX);
  endfunction

  // Non-decimal nibbles are squashed to zero on load.
  function automatic logic [3:0] bcd_sat(
    input logic [3:0] d
  );
    return (d > BCD_MAX) ? BCD_MIN : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade with ripple enable out for cascading.
// LOAD/DIN ports exist only when BCD_LOAD_EN is defined.
module bcd_digit
  import bcd_counter_pkg::*;
(
  input  logic                   CLK,
  input  logic                   CLR,
  input  logic                   CE,
  input  logic                   DIR,
`ifdef BCD_LOAD_EN
  input  logic                   LOAD,
  input  logic [BCD_DIGIT_W-1:0] DIN,
`endif
  output logic [BCD_DIGIT_W-1:0] Q,
  output logic                   CEO
);

  logic                   ld;
  logic [BCD_DIGIT_W-1:0] dval;

`ifdef BCD_LOAD_EN
  assign ld   = LOAD;
  assign dval = bcd_sat(DIN);
`else
  assign ld   = 1'b0;
  assign dval = BCD_MIN;
`endif

  always_ff @(posedge CLK) begin
    if (CLR)
      Q <= BCD_MIN;
    else if (ld)
      Q <= dval;
    else if (CE)
      Q <= bcd_step(Q, DIR);
  end

  // Suppressed during load so no stage downstream sees a stray tick.
  assign CEO = CE & ~ld & bcd_term(Q, DIR);

endmodule

// File: rtl/bcd_counter.sv
// Multi-decade up/down BCD counter built from chained bcd_digit.
// Optional parallel load is enabled by defining BCD_LOAD_EN.
module bcd_counter
  import bcd_counter_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  CE,
  input  logic                  DIR,
`ifdef BCD_LOAD_EN
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   DIN,
`endif
  output logic [4*DIGITS-1:0]   Q,
  output logic                  CEO
);

  logic [DIGITS:0] en;

  assign en[0] = CE;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit u_digit (
      .CLK  (CLK),
      .CLR  (CLR),
      .CE   (en[i]),
      .DIR  (DIR),
`ifdef BCD_LOAD_EN
      .LOAD (LOAD),
      .DIN  (DIN[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
`endif
      .Q    (Q[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
      .CEO  (en[i+1])
    );
  end

  assign CEO = en[DIGITS];

endmodule

// File: tb/tb_bcd_counter.sv
// Bench for bcd_counter: integer reference model plus directed vectors.
// Load checks are active when BCD_LOAD_EN is defined.
module tb_bcd_counter;

  localparam int D = 4;
  localparam int W = 4 * D;
  localparam int M = 10000;

  logic         CLK;
  logic         CLR;
  logic         CE;
  logic         DIR;
  logic         LOAD;
  logic [W-1:0] DIN;
  logic [W-1:0] Q;
  logic         CEO;

  int total;
  int bad;
  int mv;
  bit chk_en;
  logic ld_m;

  bcd_counter #(.DIGITS(D)) dut (
    .CLK  (CLK),
    .CLR  (CLR),
    .CE   (CE),
    .DIR  (DIR),
`ifdef BCD_LOAD_EN
    .LOAD (LOAD),
    .DIN  (DIN),
`endif
    .Q    (Q),
    .CEO  (CEO)
  );

`ifdef BCD_LOAD_EN
  assign ld_m = LOAD;
`else
  assign ld_m = 1'b0;
`endif

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int from_din(input logic [W-1:0] d);
    int v;
    int p;
    int n;
    v = 0;
    p = 1;
    for (int i = 0; i < D; i++) begin
      n = int'(d[4*i +: 4]);
      if (n > 9) n = 0;
      v = v + n * p;
      p = p * 10;
    end
    return v;
  endfunction

  // Reference: the counter value as a plain integer modulo 10^D.
  always @(posedge CLK) begin
    if (CLR)
      mv = 0;
    else if (ld_m)
      mv = from_din(DIN);
    else if (CE)
      mv = DIR ? (mv + M - 1) % M : (mv + 1) % M;
  end

  always @(negedge CLK) begin
    logic exp_ceo;
    if (chk_en) begin
      exp_ceo = CE && !ld_m &&
                (DIR ? (mv == 0) : (mv == M - 1));
      total++;
      if (Q !== to_bcd(mv)) begin
        bad++;
        $display("FAIL model_q: Q=%h expected %h", Q, to_bcd(mv));
      end
      total++;
      if (CEO !== exp_ceo) begin
        bad++;
        $display("FAIL model_ceo: CEO=%b expected %b", CEO, exp_ceo);
      end
    end
  end

  task automatic drive(
    input logic         clr,
    input logic         ld,
    input logic         ce,
    input logic         dir,
    input logic [W-1:0] din
  );
    CLR  = clr;
    LOAD = ld;
    CE   = ce;
    DIR  = dir;
    DIN  = din;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input int n, input logic ce, input logic dir);
    repeat (n) begin
      drive(1'b0, 1'b0, ce, dir, '0);
      tick();
    end
  endtask

  task automatic chk_q(input string nm, input logic [W-1:0] exp);
    total++;
    if (Q !== exp) begin
      bad++;
      $display("FAIL %s: Q=%h expected %h", nm, Q, exp);
    end
  endtask

  task automatic chk_ceo(input string nm, input logic exp);
    total++;
    if (CEO !== exp) begin
      bad++;
      $display("FAIL %s: CEO=%b expected %b", nm, CEO, exp);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    mv     = 0;
    chk_en = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    tick();
    chk_q("reset", 16'h0000);
    chk_ceo("reset_ceo", 1'b0);
    chk_en = 1'b1;

    run(10, 1'b1, 1'b0);
    chk_q("cascade10", 16'h0010);

    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, (i % 10) == 0, 1'b0, '0);
      tick();
    end
    chk_q("sparse", 16'h0012);

    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b1, '0);
    #1;
    chk_ceo("down_wrap_ceo", 1'b1);
    tick();
    chk_q("down_wrap", 16'h9999);

    drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
    #1;
    chk_ceo("up_wrap_ceo", 1'b1);
    tick();
    chk_q("up_wrap", 16'h0000);

    run(1000, 1'b1, 1'b0);
    chk_q("to1000", 16'h1000);
    run(1, 1'b1, 1'b1);
    chk_q("borrow", 16'h0999);

    run(3322, 1'b1, 1'b0);
    chk_q("to4321", 16'h4321);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h5555);
    tick();
    chk_q("prio_clr", 16'h0000);

`ifdef BCD_LOAD_EN
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h1234);
    #1;
    chk_ceo("load_ceo", 1'b0);
    tick();
    chk_q("load", 16'h1234);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h9A3F);
    tick();
    chk_q("load_bad", 16'h9030);
`endif

    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    tick();
    run(9, 1'b1, 1'b0);
    chk_q("to9", 16'h0009);
    drive(1'b0, 1'b0, 1'b1, 1'b1, '0);
    tick();
    chk_q("dir_flip", 16'h0008);

    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, (i % 2) == 0, '0);
      tick();
    end
    chk_q("hold", 16'h0008);
    chk_ceo("hold_ceo", 1'b0);

    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
